mem_access_stage: RTL and testbench

Memory-access stage of the 16-bit pipeline, directly downstream of the EXE/MEM pipeline register. It consumes that register's control and data outputs, runs loads and stores against the data memory over a req/ack handshake, and selects the write-back value. The result is registered into MEM/WB outputs. While a memory transaction is outstanding it stalls upstream stages, and it aborts transactions that exceed a timeout.

---
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU/PC-link results straight to MEM/WB,
// runs loads/stores over a req/ack handshake, stalls upstream while a memory
// transaction is outstanding and drops transactions that never get an ack.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWrite_in,
    input  logic        memWrite_in,
    input  logic [1:0]  resultSrc_in,
    input  logic [15:0] pc_plus2_in,
    input  logic [3:0]  rd_in,
    input  logic [15:0] aluRes_in,
    input  logic [15:0] op2_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_out,
    output logic        regWrite_out,
    output logic [3:0]  rd_out,
    output logic [15:0] result_out,
    output logic        mem_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Counter value seen in the last WAIT cycle that is still allowed to wait.
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        we_reg, we_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        lat_regwrite_reg, lat_regwrite_next;
    logic [3:0]  lat_rd_reg, lat_rd_next;
    logic        wb_regwrite_reg, wb_regwrite_next;
    logic [3:0]  wb_rd_reg, wb_rd_next;
    logic [15:0] wb_result_reg, wb_result_next;
    logic        err_reg, err_next;
    logic        is_mem_op;

    // Stores, and loads (result taken from memory), need the data memory.
    assign is_mem_op = memWrite_in || (resultSrc_in == 2'b01);

    // The request is purely state-derived so it cannot glitch.
    assign mem_req      = (state_reg == ST_WAIT);
    assign mem_we       = we_reg;
    assign mem_addr     = addr_reg;
    assign mem_wdata    = wdata_reg;
    assign regWrite_out = wb_regwrite_reg;
    assign rd_out       = wb_rd_reg;
    assign result_out   = wb_result_reg;
    assign mem_err      = err_reg;

    // Next-state, latch capture, MEM/WB selection and the upstream stall.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        we_next           = we_reg;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        lat_regwrite_next = lat_regwrite_reg;
        lat_rd_next       = lat_rd_reg;
        wb_regwrite_next  = wb_regwrite_reg;
        wb_rd_next        = wb_rd_reg;
        wb_result_next    = wb_result_reg;
        err_next          = err_reg;
        stall_out         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (is_mem_op) begin
                    // Capture the op so upstream inputs can be ignored while waiting.
                    stall_out         = 1'b1;
                    addr_next         = aluRes_in;
                    wdata_next        = op2_in;
                    we_next           = memWrite_in;
                    lat_regwrite_next = regWrite_in;
                    lat_rd_next       = rd_in;
                    cnt_next          = 8'd0;
                    wb_regwrite_next  = 1'b0;
                    state_next        = ST_WAIT;
                end else begin
                    wb_regwrite_next = regWrite_in;
                    wb_rd_next       = rd_in;
                    wb_result_next   = (resultSrc_in == 2'b10) ? pc_plus2_in : aluRes_in;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    // Completion wins even in the cycle the timeout would fire.
                    wb_regwrite_next = lat_regwrite_reg;
                    wb_rd_next       = lat_rd_reg;
                    wb_result_next   = we_reg ? addr_reg : mem_rdata;
                    state_next       = ST_IDLE;
                end else if (cnt_reg == CNT_LIMIT) begin
                    // Abandon the op; upstream is released in this same cycle.
                    err_next         = 1'b1;
                    wb_regwrite_next = 1'b0;
                    state_next       = ST_IDLE;
                end else begin
                    stall_out        = 1'b1;
                    cnt_next         = cnt_reg + 8'd1;
                    wb_regwrite_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // All stage state, with an asynchronous clear that also kills any request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= 8'd0;
            we_reg           <= 1'b0;
            addr_reg         <= 16'd0;
            wdata_reg        <= 16'd0;
            lat_regwrite_reg <= 1'b0;
            lat_rd_reg       <= 4'd0;
            wb_regwrite_reg  <= 1'b0;
            wb_rd_reg        <= 4'd0;
            wb_result_reg    <= 16'd0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            we_reg           <= we_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            lat_regwrite_reg <= lat_regwrite_next;
            lat_rd_reg       <= lat_rd_next;
            wb_regwrite_reg  <= wb_regwrite_next;
            wb_rd_reg        <= wb_rd_next;
            wb_result_reg    <= wb_result_next;
            err_reg          <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: randomized ops against a
// transaction-level expectation of stall/request length and write-back value.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite_in, memWrite_in;
    logic [1:0]  resultSrc_in;
    logic [15:0] pc_plus2_in, aluRes_in, op2_in;
    logic [3:0]  rd_in;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, stall_out, regWrite_out, mem_err;
    logic [3:0]  rd_out;
    logic [15:0] result_out;

    int   checks = 0;
    int   errors = 0;
    logic exp_err;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .regWrite_in(regWrite_in), .memWrite_in(memWrite_in),
        .resultSrc_in(resultSrc_in), .pc_plus2_in(pc_plus2_in),
        .rd_in(rd_in), .aluRes_in(aluRes_in), .op2_in(op2_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_out(stall_out), .regWrite_out(regWrite_out),
        .rd_out(rd_out), .result_out(result_out), .mem_err(mem_err)
    );

    task automatic set_nop();
        regWrite_in = 1'b0; memWrite_in = 1'b0; resultSrc_in = 2'b00;
        pc_plus2_in = 16'd0; rd_in = 4'd0; aluRes_in = 16'd0; op2_in = 16'd0;
    endtask

    task automatic set_garbage();
        regWrite_in  = 1'($urandom);
        memWrite_in  = 1'($urandom);
        resultSrc_in = 2'($urandom);
        pc_plus2_in  = 16'($urandom);
        rd_in        = 4'($urandom);
        aluRes_in    = 16'($urandom);
        op2_in       = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; set_nop(); mem_ack = 1'b0; mem_rdata = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mem_side got=%h want=0", {mem_req, mem_we, mem_addr, mem_wdata, stall_out});
        end
        checks++;
        if ({regWrite_out, rd_out, result_out, mem_err} !== 22'd0) begin
            errors++;
            $display("FAIL reset_wb_side got=%h want=0", {regWrite_out, rd_out, result_out, mem_err});
        end
        reset = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_alu();
        for (int t = 0; t < 24; t++) begin
            logic [15:0] exp_res;
            if (t == 0) begin
                set_nop(); resultSrc_in = 2'b00; aluRes_in = 16'h1234; rd_in = 4'd5; regWrite_in = 1'b1;
            end else if (t == 1) begin
                set_nop(); resultSrc_in = 2'b10; pc_plus2_in = 16'h0042; rd_in = 4'd14; regWrite_in = 1'b1;
            end else begin
                int r;
                set_garbage();
                memWrite_in = 1'b0;
                r = int'($urandom_range(0, 2));
                resultSrc_in = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
            end
            exp_res = (resultSrc_in == 2'b10) ? pc_plus2_in : aluRes_in;
            mem_ack = 1'($urandom);
            #2;
            checks++;
            if (stall_out !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL alu_no_stall t=%0d got stall=%b req=%b want 0 0", t, stall_out, mem_req);
            end
            @(posedge clk);
            #1;
            checks++;
            if (result_out !== exp_res || rd_out !== rd_in || regWrite_out !== regWrite_in) begin
                errors++;
                $display("FAIL alu_wb t=%0d got res=%h rd=%0d we=%b want res=%h rd=%0d we=%b",
                         t, result_out, rd_out, regWrite_out, exp_res, rd_in, regWrite_in);
            end
        end
        mem_ack = 1'b0;
    endtask

    // Loads and stores with varying ack delay (never past the timeout), and
    // random idle gaps so some ops follow each other back to back.
    task automatic test_mem_ops();
        for (int t = 0; t < 24; t++) begin
            logic        st, rw;
            logic [15:0] a, wd, rdat, exp_res;
            logic [3:0]  rd;
            int          ack_at;
            if (t == 0) begin
                st = 1'b0; a = 16'h0100; wd = 16'h5555; rw = 1'b1; rd = 4'd7; ack_at = 3; rdat = 16'hBEEF;
            end else if (t == 1) begin
                st = 1'b1; a = 16'h0200; wd = 16'hA5A5; rw = 1'b0; rd = 4'd3; ack_at = 1; rdat = 16'h1111;
            end else begin
                st = 1'($urandom); a = 16'($urandom); wd = 16'($urandom); rw = 1'($urandom);
                rd = 4'($urandom); rdat = 16'($urandom);
                ack_at = (t % 5 == 0) ? TO : int'($urandom_range(1, TO));
            end
            exp_res = st ? a : rdat;
            set_nop();
            regWrite_in = rw; memWrite_in = st; resultSrc_in = st ? 2'b00 : 2'b01;
            aluRes_in = a; op2_in = wd; rd_in = rd; pc_plus2_in = 16'($urandom);
            for (int c = 0; c <= ack_at; c++) begin
                if (c > 0) set_garbage();
                mem_ack   = (c == 0) ? 1'($urandom) : (c == ack_at);
                mem_rdata = (c == ack_at) ? rdat : 16'($urandom);
                #2;
                checks++;
                if (stall_out !== (c < ack_at)) begin
                    errors++;
                    $display("FAIL mem_stall t=%0d c=%0d got=%b want=%b", t, c, stall_out, (c < ack_at));
                end
                checks++;
                if (mem_req !== (c > 0)) begin
                    errors++;
                    $display("FAIL mem_req t=%0d c=%0d got=%b want=%b", t, c, mem_req, (c > 0));
                end
                if (c > 0) begin
                    checks++;
                    if ({mem_we, mem_addr, mem_wdata} !== {st, a, wd} || regWrite_out !== 1'b0) begin
                        errors++;
                        $display("FAIL mem_bus t=%0d c=%0d got we=%b addr=%h wd=%h wbwe=%b want we=%b addr=%h wd=%h wbwe=0",
                                 t, c, mem_we, mem_addr, mem_wdata, regWrite_out, st, a, wd);
                    end
                end
                @(posedge clk);
                #1;
            end
            mem_ack = 1'b0;
            checks++;
            if (regWrite_out !== rw || rd_out !== rd || result_out !== exp_res || mem_req !== 1'b0 || mem_err !== exp_err) begin
                errors++;
                $display("FAIL mem_wb t=%0d got we=%b rd=%0d res=%h req=%b err=%b want we=%b rd=%0d res=%h req=0 err=%b",
                         t, regWrite_out, rd_out, result_out, mem_req, mem_err, rw, rd, exp_res, exp_err);
            end
            if ($urandom_range(0, 1) == 0) begin
                set_nop();
                @(posedge clk);
                #1;
            end
        end
        set_nop();
    endtask

    task automatic test_timeout();
        set_nop();
        regWrite_in = 1'b1; resultSrc_in = 2'b01; aluRes_in = 16'h0300; rd_in = 4'd9;
        mem_ack = 1'b0;
        for (int c = 0; c <= TO; c++) begin
            if (c > 0) set_garbage();
            #2;
            checks++;
            if (stall_out !== (c < TO) || mem_req !== (c > 0)) begin
                errors++;
                $display("FAIL timeout_wait c=%0d got stall=%b req=%b want stall=%b req=%b",
                         c, stall_out, mem_req, (c < TO), (c > 0));
            end
            @(posedge clk);
            #1;
        end
        exp_err = 1'b1;
        checks++;
        if (mem_err !== 1'b1 || regWrite_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort got err=%b wbwe=%b req=%b want err=1 wbwe=0 req=0",
                     mem_err, regWrite_out, mem_req);
        end
        set_nop();
        regWrite_in = 1'b1; aluRes_in = 16'h4321; rd_in = 4'd2;
        #2;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next_stall got=%b want=0", stall_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_out !== 16'h4321 || regWrite_out !== 1'b1 || rd_out !== 4'd2 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next_alu got res=%h we=%b rd=%0d err=%b want res=4321 we=1 rd=2 err=1",
                     result_out, regWrite_out, rd_out, mem_err);
        end
        set_nop();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b want=1", mem_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        set_nop();
        memWrite_in = 1'b1; aluRes_in = 16'h0400; op2_in = 16'h7777; rd_in = 4'd1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        set_nop();
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got req=%b want=1", mem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out, regWrite_out, rd_out, result_out, mem_err} !== 57'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h want=0",
                     {mem_req, mem_we, mem_addr, mem_wdata, stall_out, regWrite_out, rd_out, result_out, mem_err});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        regWrite_in = 1'b1; aluRes_in = 16'hCAFE; rd_in = 4'd11;
        #2;
        checks++;
        if (stall_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle got stall=%b req=%b want 0 0", stall_out, mem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_out !== 16'hCAFE || regWrite_out !== 1'b1 || rd_out !== 4'd11 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_alu got res=%h we=%b rd=%0d err=%b want res=cafe we=1 rd=11 err=0",
                     result_out, regWrite_out, rd_out, mem_err);
        end
        set_nop();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_ops();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
